// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared constants for the instruction/data memory port arbiter:
//   FSM state encodings, requester IDs and the round-robin pick helper.
package mem_port_arbiter_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] REQ_I  = 3'd1;
  localparam logic [2:0] WAIT_I = 3'd2;
  localparam logic [2:0] REQ_D  = 3'd3;
  localparam logic [2:0] WAIT_D = 3'd4;

  localparam logic REQ_ID_I = 1'b0;
  localparam logic REQ_ID_D = 1'b1;

  // D wins when it is the only requester, or on a tie when I was served last.
  function automatic logic pick_d(input logic i_req, input logic d_req, input logic last_gnt);
    return d_req & (~i_req | (last_gnt == REQ_ID_I));
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between instruction fetch (I) and
//   load/store (D). One transaction in flight at a time, round-robin on ties,
//   and a stall output that holds the pipeline until the requester is served.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   i_req/i_addr        fetch request (level) and address
//   i_rvalid/i_rdata    fetch done pulse and instruction
//   d_req/d_we/d_be     load/store request, write enable, byte enables
//   d_addr/d_wdata      load/store address and store data
//   d_rvalid/d_rdata    load data valid / store ack pulse and load data
//   mem_req..mem_wdata  request to the memory wrapper, held until mem_gnt
//   mem_gnt             memory accepted the request
//   mem_rvalid/rdata    memory response (one per transaction)
//   stall               some requester is still waiting
//   proto_err           sticky: memory responded while nothing was waiting
//
// state  | meaning
// -------+-----------------------------------------------
// IDLE   | free; picks the next requester this cycle
// REQ_I  | fetch request presented, waiting for mem_gnt
// WAIT_I | fetch accepted, waiting for mem_rvalid
// REQ_D  | load/store presented, waiting for mem_gnt
// WAIT_D | load/store accepted, waiting for mem_rvalid
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_rvalid,
  output logic [DATA_W-1:0]   i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall,
  output logic                proto_err
);

  localparam int BE_W = DATA_W / 8;

  logic [2:0]        state_q, state_d;
  logic              last_gnt_q, last_gnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              we_q, we_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              proto_err_q, proto_err_d;
  logic              in_wait;

  assign in_wait = (state_q == WAIT_I) || (state_q == WAIT_D);

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    addr_d      = addr_q;
    we_d        = we_q;
    be_d        = be_q;
    wdata_d     = wdata_q;
    // A response is only legal while a transaction is waiting for it; this
    // includes a response arriving in the same REQ cycle as its grant.
    proto_err_d = proto_err_q | (mem_rvalid & ~in_wait);

    case (state_q)
      IDLE: begin
        // Attributes are captured here so requester changes after the pick
        // cannot disturb a request that the memory has not yet accepted.
        if (pick_d(i_req, d_req, last_gnt_q)) begin
          state_d    = REQ_D;
          last_gnt_d = REQ_ID_D;
          addr_d     = d_addr;
          we_d       = d_we;
          be_d       = d_we ? d_be : {BE_W{1'b1}};
          wdata_d    = d_wdata;
        end else if (i_req) begin
          state_d    = REQ_I;
          last_gnt_d = REQ_ID_I;
          addr_d     = i_addr;
          we_d       = 1'b0;
          be_d       = {BE_W{1'b1}};
          wdata_d    = '0;
        end
      end
      REQ_I:   if (mem_gnt)    state_d = WAIT_I;
      WAIT_I:  if (mem_rvalid) state_d = IDLE;
      REQ_D:   if (mem_gnt)    state_d = WAIT_D;
      WAIT_D:  if (mem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_gnt_q  <= REQ_ID_I;
      addr_q      <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      wdata_q     <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      be_q        <= be_d;
      wdata_q     <= wdata_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign mem_req   = (state_q == REQ_I) || (state_q == REQ_D);
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign i_rvalid  = mem_rvalid & (state_q == WAIT_I);
  assign d_rvalid  = mem_rvalid & (state_q == WAIT_D);
  assign i_rdata   = i_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid ? mem_rdata : '0;

  assign stall     = (i_req & ~i_rvalid) | (d_req & ~d_rvalid);
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed scenarios for the arbiter followed by a randomized run in which
//   the bench plays both requesters and the memory, predicting every output
//   from the arbitration and handshake rules at transaction level.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall;
  logic        proto_err;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_rvalid   (i_rvalid),
    .i_rdata    (i_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_be       (d_be),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .stall      (stall),
    .proto_err  (proto_err)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    i_req = 0; i_addr = 0;
    d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
  endtask

  // Ends at the negedge of the first cycle after reset, outputs checked.
  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    clear_inputs();
    @(negedge clk);
    reset = 0;
    #1;
    chk("rst_mem_req",   mem_req,   0);
    chk("rst_mem_we",    mem_we,    0);
    chk("rst_mem_be",    mem_be,    0);
    chk("rst_mem_addr",  mem_addr,  0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_i_rvalid",  i_rvalid,  0);
    chk("rst_d_rvalid",  d_rvalid,  0);
    chk("rst_proto_err", proto_err, 0);
    chk("rst_stall",     stall,     0);
  endtask

  task automatic chk_req(input string tag, input logic [31:0] e_addr, input bit e_we,
                         input logic [3:0] e_be, input logic [31:0] e_wd);
    chk($sformatf("%s_mem_req", tag),  mem_req,  1);
    chk($sformatf("%s_mem_addr", tag), mem_addr, e_addr);
    chk($sformatf("%s_mem_we", tag),   mem_we,   e_we);
    chk($sformatf("%s_mem_be", tag),   mem_be,   e_be);
    if (e_we) chk($sformatf("%s_mem_wdata", tag), mem_wdata, e_wd);
    chk($sformatf("%s_stall", tag), stall, i_req | d_req);
  endtask

  // Called in an IDLE cycle with the requests already driven; returns at the
  // negedge of the IDLE cycle that follows the response.
  task automatic do_txn(input string tag, input bit own_d, input logic [31:0] e_addr,
                        input bit e_we, input logic [3:0] e_be, input logic [31:0] e_wd,
                        input int gnt_wait, input bit scramble, input logic [31:0] rdat);
    bit ei, ed;
    #1;
    chk($sformatf("%s_pick_mem_req", tag), mem_req, 0);
    chk($sformatf("%s_pick_stall", tag), stall, i_req | d_req);
    @(negedge clk);
    for (int k = 0; k < gnt_wait; k++) begin
      mem_gnt = 0;
      #1;
      chk_req($sformatf("%s_hold%0d", tag, k), e_addr, e_we, e_be, e_wd);
      if (scramble) begin
        d_addr  = $urandom();
        d_wdata = $urandom();
        d_be    = 4'($urandom_range(15));
        i_addr  = $urandom();
      end
      @(negedge clk);
    end
    mem_gnt = 1;
    #1;
    chk_req($sformatf("%s_gnt", tag), e_addr, e_we, e_be, e_wd);
    @(negedge clk);
    mem_gnt    = 0;
    mem_rvalid = 1;
    mem_rdata  = rdat;
    #1;
    ei = !own_d;
    ed = own_d;
    chk($sformatf("%s_i_rvalid", tag), i_rvalid, ei);
    chk($sformatf("%s_i_rdata", tag),  i_rdata,  ei ? rdat : 32'h0);
    chk($sformatf("%s_d_rvalid", tag), d_rvalid, ed);
    chk($sformatf("%s_d_rdata", tag),  d_rdata,  ed ? rdat : 32'h0);
    chk($sformatf("%s_rv_stall", tag), stall, (i_req & ~ei) | (d_req & ~ed));
    chk($sformatf("%s_rv_mem_req", tag), mem_req, 0);
    @(negedge clk);
    mem_rvalid = 0;
    mem_rdata  = 0;
  endtask

  // Bench acts as both requesters and the memory. ph: 0 free, 1 request
  // outstanding, 2 accepted and awaiting response.
  task automatic run_random(input int ncyc);
    bit          pend_i = 0, pend_d = 0;
    bit          gnt, rv, ei, ed;
    int          ph = 0, owner = 0, last = 0, gd = 0, rd = 0;
    logic [31:0] c_addr = 0, c_wd = 0, rdat;
    logic        c_we = 0;
    logic [3:0]  c_be = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (!pend_i && $urandom_range(2) == 0) begin
        pend_i = 1;
        i_addr = $urandom() & 32'hFFFF_FFFC;
      end
      if (!pend_d && $urandom_range(2) == 0) begin
        pend_d  = 1;
        d_addr  = $urandom() & 32'hFFFF_FFFC;
        d_we    = 1'($urandom_range(1));
        d_be    = 4'($urandom_range(15));
        d_wdata = $urandom();
      end
      if (ph != 0 && $urandom_range(3) == 0) begin
        if (owner == 1) begin
          d_addr  = $urandom();
          d_wdata = $urandom();
          d_be    = 4'($urandom_range(15));
          d_we    = 1'($urandom_range(1));
        end else begin
          i_addr = $urandom();
        end
      end
      i_req = pend_i;
      d_req = pend_d;
      gnt   = (ph == 1) && (gd == 0);
      rv    = (ph == 2) && (rd == 0);
      rdat  = $urandom();
      mem_gnt    = gnt;
      mem_rvalid = rv;
      mem_rdata  = rdat;
      #1;
      ei = rv && owner == 0;
      ed = rv && owner == 1;
      chk("rnd_mem_req", mem_req, ph == 1);
      if (ph == 1) begin
        chk("rnd_mem_addr", mem_addr, c_addr);
        chk("rnd_mem_we",   mem_we,   c_we);
        chk("rnd_mem_be",   mem_be,   c_be);
        if (c_we) chk("rnd_mem_wdata", mem_wdata, c_wd);
      end
      chk("rnd_i_rvalid", i_rvalid, ei);
      chk("rnd_i_rdata",  i_rdata,  ei ? rdat : 32'h0);
      chk("rnd_d_rvalid", d_rvalid, ed);
      chk("rnd_d_rdata",  d_rdata,  ed ? rdat : 32'h0);
      chk("rnd_stall", stall, (pend_i & ~ei) | (pend_d & ~ed));
      chk("rnd_proto_err", proto_err, 0);
      case (ph)
        0: if (pend_i || pend_d) begin
          owner = (pend_d && (!pend_i || last == 0)) ? 1 : 0;
          last  = owner;
          if (owner == 1) begin
            c_addr = d_addr; c_we = d_we; c_be = d_we ? d_be : 4'hF; c_wd = d_wdata;
          end else begin
            c_addr = i_addr; c_we = 0; c_be = 4'hF; c_wd = 0;
          end
          ph = 1;
          gd = $urandom_range(3);
        end
        1: if (gnt) begin
          ph = 2;
          rd = $urandom_range(3);
        end else gd--;
        default: if (rv) begin
          ph = 0;
          if (owner == 1) pend_d = 0; else pend_i = 0;
        end else rd--;
      endcase
    end
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    do_reset();

    // single fetch, minimum latency
    i_req = 1; i_addr = 32'h0000_0010;
    do_txn("t1", 0, 32'h10, 0, 4'hF, 32'h0, 0, 0, 32'h0050_0093);
    i_req = 0;
    #1;
    chk("t1_after_stall", stall, 0);
    chk("t1_after_mem_req", mem_req, 0);

    // tie after reset: D first, then I, then D again
    do_reset();
    i_req = 1; i_addr = 32'h20;
    d_req = 1; d_we = 1; d_be = 4'h3; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF;
    do_txn("t2_d1", 1, 32'h100, 1, 4'h3, 32'hDEAD_BEEF, 0, 0, 32'h0);
    do_txn("t2_i",  0, 32'h20,  0, 4'hF, 32'h0,        0, 0, 32'h0000_0013);
    do_txn("t2_d2", 1, 32'h100, 1, 4'h3, 32'hDEAD_BEEF, 1, 0, 32'h0);
    i_req = 0; d_req = 0;

    // grant withheld; requester attributes change under the outstanding request
    d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h200; d_wdata = 32'h1234_5678;
    do_txn("t3", 1, 32'h200, 1, 4'hF, 32'h1234_5678, 4, 1, 32'h0);
    d_req = 0;

    // reset while waiting for a load response, then a late response
    d_req = 1; d_we = 0; d_be = 4'h0; d_addr = 32'h300;
    #1;
    @(negedge clk);
    mem_gnt = 1;
    #1;
    chk("t4_mem_req", mem_req, 1);
    @(negedge clk);
    mem_gnt = 0;
    reset = 1;
    d_req = 0;
    @(negedge clk);
    reset = 0;
    mem_rvalid = 1;
    mem_rdata = 32'hAA;
    #1;
    chk("t4_mem_req_after_rst", mem_req, 0);
    chk("t4_late_d_rvalid", d_rvalid, 0);
    chk("t4_late_i_rvalid", i_rvalid, 0);
    chk("t4_late_d_rdata", d_rdata, 0);
    @(negedge clk);
    mem_rvalid = 0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("t4_proto_err%0d", k), proto_err, 1);
      @(negedge clk);
    end
    do_reset();

    // response with nothing outstanding
    mem_rvalid = 1;
    mem_rdata = 32'h55;
    #1;
    chk("t5_idle_i_rvalid", i_rvalid, 0);
    chk("t5_idle_d_rvalid", d_rvalid, 0);
    @(negedge clk);
    mem_rvalid = 0;
    #1;
    chk("t5_proto_err", proto_err, 1);
    do_reset();

    // stall follows a load until its response, drops once d_req falls
    d_req = 1; d_we = 0; d_be = 4'h5; d_addr = 32'h40;
    do_txn("t5_ld", 1, 32'h40, 0, 4'hF, 32'h0, 2, 0, 32'hCAFE_0001);
    d_req = 0;
    #1;
    chk("t5_stall_off", stall, 0);

    // grant and response in the same REQ cycle: grant taken, response flagged
    do_reset();
    d_req = 1; d_we = 1; d_be = 4'hC; d_addr = 32'h80; d_wdata = 32'h0BAD_F00D;
    #1;
    @(negedge clk);
    mem_gnt = 1;
    mem_rvalid = 1;
    #1;
    chk("t6_d_rvalid_in_req", d_rvalid, 0);
    chk("t6_mem_be", mem_be, 4'hC);
    @(negedge clk);
    mem_gnt = 0;
    mem_rvalid = 0;
    #1;
    chk("t6_proto_err", proto_err, 1);
    chk("t6_in_wait_mem_req", mem_req, 0);
    @(negedge clk);
    mem_rvalid = 1;
    mem_rdata = 32'h77;
    #1;
    chk("t6_d_rvalid", d_rvalid, 1);
    @(negedge clk);
    mem_rvalid = 0;
    d_req = 0;

    do_reset();
    run_random(3000);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
